// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with one-cycle turnaround gap and hold timeout.
// Grants are registered; a stuck owner is forcibly released after TIMEOUT cycles.
module bus_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] done,
    output logic [NUM_REQ-1:0] gnt,
    output logic [1:0]         gnt_id,
    output logic               busy,
    output logic               timeout_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(TIMEOUT - 1);
    localparam logic [1:0] PTR_RST   = 2'(NUM_REQ - 1);

    state_t             state, state_n;
    logic [NUM_REQ-1:0] gnt_n;
    logic [1:0]         gnt_id_n;
    logic               busy_n;
    logic               terr_n;
    logic [7:0]         hold_cnt, hold_n;
    logic [1:0]         ptr, ptr_n;

    logic               found;
    logic [1:0]         pick_id;
    logic               own_done;
    logic               own_req;

    // Rotating priority: search upward from the slot after the last owner.
    always_comb begin
        int idx;
        idx     = 0;
        found   = 1'b0;
        pick_id = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_REQ)
                idx = idx - NUM_REQ;
            if (!found && req[idx]) begin
                found   = 1'b1;
                pick_id = 2'(idx);
            end
        end
    end

    assign own_done = |(done & gnt);
    assign own_req  = |(req & gnt);

    always_comb begin
        state_n  = state;
        gnt_n    = gnt;
        gnt_id_n = gnt_id;
        busy_n   = busy;
        terr_n   = 1'b0;
        hold_n   = hold_cnt;
        ptr_n    = ptr;
        unique case (state)
            IDLE: begin
                gnt_n    = '0;
                gnt_id_n = '0;
                busy_n   = 1'b0;
                if (found) begin
                    state_n         = OWN;
                    gnt_n[pick_id]  = 1'b1;
                    gnt_id_n        = pick_id;
                    busy_n          = 1'b1;
                    hold_n          = '0;
                    ptr_n           = pick_id;
                end
            end
            OWN: begin
                // A real release always wins over a coincident timeout.
                if (own_done || !own_req) begin
                    state_n  = GAP;
                    gnt_n    = '0;
                    gnt_id_n = '0;
                    busy_n   = 1'b0;
                    hold_n   = '0;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_n  = GAP;
                    gnt_n    = '0;
                    gnt_id_n = '0;
                    busy_n   = 1'b0;
                    hold_n   = '0;
                    terr_n   = 1'b1;
                end else begin
                    hold_n = hold_cnt + 8'd1;
                end
            end
            GAP: begin
                state_n  = IDLE;
                gnt_n    = '0;
                gnt_id_n = '0;
                busy_n   = 1'b0;
            end
            default: begin
                state_n  = IDLE;
                gnt_n    = '0;
                gnt_id_n = '0;
                busy_n   = 1'b0;
                hold_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            gnt         <= '0;
            gnt_id      <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            hold_cnt    <= '0;
            ptr         <= PTR_RST;
        end else begin
            state       <= state_n;
            gnt         <= gnt_n;
            gnt_id      <= gnt_id_n;
            busy        <= busy_n;
            timeout_err <= terr_n;
            hold_cnt    <= hold_n;
            ptr         <= ptr_n;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: single owner, round-robin, timeout,
// done/timeout collision, reset mid-grant and request drop.
module tb_bus_arbiter;

    logic       clk;
    logic       rst;
    logic [2:0] req;
    logic [2:0] done;
    logic [2:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       timeout_err;

    int checks;
    int errors;

    bus_arbiter #(
        .NUM_REQ(3),
        .TIMEOUT(8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .done       (done),
        .gnt        (gnt),
        .gnt_id     (gnt_id),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = '0;
        done = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_gnt"}, 32'(gnt), 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_id"}, 32'(gnt_id), 32'h0);
    endtask

    initial begin
        logic [1:0] rr_exp [4];
        checks = 0;
        errors = 0;
        rst  = 1'b1;
        req  = '0;
        done = '0;
        tick();
        tick();
        chk_idle("rst");
        chk("rst_terr", 32'(timeout_err), 32'h0);
        rst = 1'b0;
        tick();
        chk_idle("idle_noreq");

        // single requester, done 4 cycles after grant
        req = 3'b010;
        tick();
        chk("s_gnt", 32'(gnt), 32'h2);
        chk("s_id", 32'(gnt_id), 32'h1);
        chk("s_busy", 32'(busy), 32'h1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("s_hold", 32'(gnt), 32'h2);
        end
        done = 3'b010;
        tick();
        chk_idle("s_rel");
        chk("s_rel_terr", 32'(timeout_err), 32'h0);
        done = '0;
        tick();
        chk("s_gap", 32'(gnt), 32'h0);
        tick();
        chk("s_regnt", 32'(gnt), 32'h2);
        chk("s_regnt_id", 32'(gnt_id), 32'h1);

        // round robin from reset pointer
        do_reset();
        rr_exp[0] = 2'd0;
        rr_exp[1] = 2'd1;
        rr_exp[2] = 2'd2;
        rr_exp[3] = 2'd0;
        req = 3'b111;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rr_gnt", 32'(gnt), 32'(3'b001 << rr_exp[k]));
            chk("rr_id", 32'(gnt_id), 32'(rr_exp[k]));
            done = 3'(3'b001 << rr_exp[k]);
            tick();
            chk("rr_rel", 32'(gnt), 32'h0);
            done = '0;
            tick();
            chk("rr_gap", 32'(gnt), 32'h0);
        end

        // timeout with TIMEOUT=8
        do_reset();
        req = 3'b100;
        tick();
        chk("to_gnt", 32'(gnt), 32'h4);
        for (int i = 1; i < 8; i++) begin
            tick();
            chk("to_hold", 32'(gnt), 32'h4);
            chk("to_noerr", 32'(timeout_err), 32'h0);
        end
        tick();
        chk_idle("to_rel");
        chk("to_err", 32'(timeout_err), 32'h1);
        tick();
        chk("to_err_clr", 32'(timeout_err), 32'h0);
        chk("to_gap", 32'(gnt), 32'h0);
        tick();
        chk("to_regnt", 32'(gnt), 32'h4);

        // done in the timeout cycle, non-owner done ignored
        do_reset();
        req = 3'b001;
        tick();
        chk("co_gnt", 32'(gnt), 32'h1);
        done = 3'b010;
        tick();
        chk("co_foreign", 32'(gnt), 32'h1);
        done = '0;
        for (int i = 0; i < 6; i++) tick();
        chk("co_last", 32'(gnt), 32'h1);
        done = 3'b001;
        tick();
        chk_idle("co_rel");
        chk("co_terr", 32'(timeout_err), 32'h0);
        done = '0;
        req  = '0;

        // reset during ownership
        do_reset();
        req = 3'b100;
        tick();
        chk("rm_gnt", 32'(gnt), 32'h4);
        chk("rm_id", 32'(gnt_id), 32'h2);
        tick();
        rst = 1'b1;
        tick();
        chk_idle("rm_rst");
        chk("rm_terr", 32'(timeout_err), 32'h0);
        rst = 1'b0;
        req = 3'b101;
        tick();
        chk("rm_next", 32'(gnt), 32'h1);
        chk("rm_next_id", 32'(gnt_id), 32'h0);

        // owner drops request without done
        do_reset();
        req = 3'b010;
        tick();
        chk("rd_gnt", 32'(gnt), 32'h2);
        tick();
        req = 3'b000;
        tick();
        chk_idle("rd_rel");
        chk("rd_terr", 32'(timeout_err), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
